ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares one single-port, synchronous-read, word-wide block RAM (1-cycle read latency,
//  read-first, byte address internally shifted >>2, no byte enables) between the core's
//  instruction-fetch and data ports. Arbitrates per cycle, returns read data with
//  req/gnt/rvalid handshakes, and turns sub-word stores into read-modify-write sequences.
//  Sits in the testbench memory model between the core and the RAM.
// PARAMETERS
//  ADDR_W   14  byte-address width on all ports (clog2(MEM_SIZE*4), MEM_SIZE=4096)
//  ARB_RR   1   1: round-robin on contention; 0: data port always wins
// PORTS
//  clk            in   1       clock, all state on rising edge
//  rstn           in   1       reset, asynchronous, active-low
//  instr_req_i    in   1       fetch request; held with addr until instr_gnt_o
//  instr_addr_i   in   ADDR_W  fetch byte address
//  instr_gnt_o    out  1       fetch accepted this cycle (combinational)
//  instr_rvalid_o out  1       instr_rdata_o valid; exactly 1 cycle after gnt
//  instr_rdata_o  out  32      fetched word
//  data_req_i     in   1       load/store request; held with all fields until data_gnt_o
//  data_we_i      in   1       1 = store
//  data_be_i      in   4       byte enables for stores (bit i = bits 8i+7:8i)
//  data_addr_i    in   ADDR_W  byte address
//  data_wdata_i   in   32      store data, already lane-aligned
//  data_gnt_o     out  1       data request accepted this cycle (combinational)
//  data_rvalid_o  out  1       response: load data, or store completion
//  data_rdata_o   out  32      load word; undefined for stores
//  ram_we_o       out  1       RAM write enable
//  ram_addr_o     out  ADDR_W  RAM byte address
//  ram_din_o      out  32      RAM write data
//  ram_dout_i     in   32      RAM registered read data (addr of previous cycle)
// BEHAVIOUR
//  Reset: state=ST_IDLE, last_winner=instr, both rvalid=0, resp owner=NONE; ram_we_o=0,
//   ram_addr_o=0, ram_din_o=0 while idle. Reset mid-transaction drops it; no rvalid issued.
//  ST_IDLE: grant at most one requester per cycle; ram_addr_o/ram_we_o/ram_din_o driven
//   combinationally from the winner in the grant cycle. No request: we=0, addr=0.
//  Contention: ARB_RR=1 -> winner is port that did not win last contention-or-grant
//   (last_winner updated on every grant); ARB_RR=0 -> data wins.
//  Read (instr, or data with we=0): 1 RAM cycle; rvalid of that port next cycle with
//   rdata = ram_dout_i. Back-to-back grants allowed every cycle (throughput 1/cycle).
//  Store be=4'hF: ram_we_o=1 in grant cycle; data_rvalid_o next cycle.
//  Store be=4'h0: no RAM write (we=0, read issued harmlessly); data_rvalid_o next cycle.
//  Store partial be: grant cycle issues read (we=0) and latches addr/be/wdata;
//   -> ST_RMW. ST_RMW cycle: ram_we_o=1, same addr, din = per-byte merge (be=1: wdata,
//   be=0: ram_dout_i); both gnt forced 0; -> ST_IDLE; data_rvalid_o the following cycle.
//   Partial-store latency 2 cycles gnt->rvalid; next grant possible in the cycle of rvalid.
//  Response owner register records which port's rvalid fires next cycle; never both.
//  rdata outputs: both driven from ram_dout_i; only meaningful when own rvalid=1.
//  Address passed through unmodified (low 2 bits ignored by RAM); no misalignment check.
//  Requester dropping req before gnt: protocol violation, behaviour unspecified.
// STRUCTURE
//  Package ram_arb_pkg: typedef state_e {ST_IDLE, ST_RMW}; owner_e {OWN_NONE,
//   OWN_INSTR, OWN_DATA}; function be_merge(old, new, be) -> 32-bit merged word.
//  Single module, no sub-module: arbiter comb logic, 2-state FSM, RMW latch regs,
//   response-owner reg. Instantiated beside rams_init_file in the tb top.
// TESTING
//  1 Reset with instr_req=1 held: gnt=0, rvalid=0, ram_we=0 while rstn=0; gnt on 1st edge after.
//  2 Fetch 0x0010 (RAM[4]=0xDEADBEEF): gnt cycle n, instr_rvalid n+1, rdata=0xDEADBEEF.
//  3 ARB_RR=1, both req continuously: grants alternate instr,data,instr,...; ARB_RR=0: data only.
//  4 Store be=4'b0101 wdata=0x11223344 to 0x0020 (old 0xAABBCCDD): gnt, 1 stall cycle
//    (both gnt=0), RAM[8]=0xAA22CC44, data_rvalid 2 cycles after gnt.
//  5 Full store 0x0030=0xCAFEF00D then load 0x0030 back-to-back: rvalid n+1, n+2; load=0xCAFEF00D.
//  6 Assert rstn=0 during ST_RMW: RAM[word] unchanged, no rvalid, FSM ST_IDLE after release.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and the byte-lane merge helper for the instruction/data RAM port arbiter.
package ram_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RMW  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  // Byte lanes with be=1 take new_word, the rest keep old_word.
  function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/ram_port_arbiter.sv
// Shares one single-port synchronous-read RAM between fetch and data ports; sub-word stores
// become a read cycle followed by a merged write cycle.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int ARB_RR = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              instr_req_i,
  input  logic [ADDR_W-1:0] instr_addr_i,
  output logic              instr_gnt_o,
  output logic              instr_rvalid_o,
  output logic [31:0]       instr_rdata_o,
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [3:0]        data_be_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [31:0]       data_wdata_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  output logic [31:0]       data_rdata_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_din_o,
  input  logic [31:0]       ram_dout_i
);

  state_e            state_reg, state_next;
  owner_e            owner_reg, owner_next;
  logic              last_data_reg, last_data_next;
  logic [ADDR_W-1:0] rmw_addr_reg;
  logic [3:0]        rmw_be_reg;
  logic [31:0]       rmw_wdata_reg;

  logic idle, in_rmw, data_wins, grant_instr, grant_data, partial_store, full_store;

  // Holding reset low also blocks grants, so nothing reaches the RAM while in reset.
  always_comb begin
    idle          = rstn && (state_reg == ST_IDLE);
    in_rmw        = rstn && (state_reg == ST_RMW);
    data_wins     = (ARB_RR == 0) || !last_data_reg;
    grant_data    = idle && data_req_i && (!instr_req_i || data_wins);
    grant_instr   = idle && instr_req_i && !grant_data;
    full_store    = data_we_i && (data_be_i == 4'hF);
    partial_store = data_we_i && (data_be_i != 4'hF) && (data_be_i != 4'h0);
  end

  assign instr_gnt_o    = grant_instr;
  assign data_gnt_o     = grant_data;
  assign instr_rvalid_o = (owner_reg == OWN_INSTR);
  assign data_rvalid_o  = (owner_reg == OWN_DATA);
  assign instr_rdata_o  = ram_dout_i;
  assign data_rdata_o   = ram_dout_i;

  // The RMW write cycle merges against the word read back during the grant cycle.
  always_comb begin
    ram_we_o   = 1'b0;
    ram_addr_o = '0;
    ram_din_o  = '0;
    if (in_rmw) begin
      ram_we_o   = 1'b1;
      ram_addr_o = rmw_addr_reg;
      ram_din_o  = be_merge(ram_dout_i, rmw_wdata_reg, rmw_be_reg);
    end else if (grant_data) begin
      ram_addr_o = data_addr_i;
      if (full_store) begin
        ram_we_o  = 1'b1;
        ram_din_o = data_wdata_i;
      end
    end else if (grant_instr) begin
      ram_addr_o = instr_addr_i;
    end
  end

  always_comb begin
    state_next     = ST_IDLE;
    owner_next     = OWN_NONE;
    last_data_next = last_data_reg;
    if (state_reg == ST_RMW) begin
      owner_next = OWN_DATA;
    end else if (grant_data) begin
      last_data_next = 1'b1;
      if (partial_store) state_next = ST_RMW;
      else               owner_next = OWN_DATA;
    end else if (grant_instr) begin
      last_data_next = 1'b0;
      owner_next     = OWN_INSTR;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= ST_IDLE;
      owner_reg     <= OWN_NONE;
      last_data_reg <= 1'b0;
      rmw_addr_reg  <= '0;
      rmw_be_reg    <= '0;
      rmw_wdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      last_data_reg <= last_data_next;
      if (grant_data) begin
        rmw_addr_reg  <= data_addr_i;
        rmw_be_reg    <= data_be_i;
        rmw_wdata_reg <= data_wdata_i;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed scenarios plus randomized traffic against a transaction-level memory/arbitration model.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        instr_req, instr_gnt, instr_rvalid;
  logic [13:0] instr_addr;
  logic [31:0] instr_rdata;
  logic        data_req, data_we, data_gnt, data_rvalid;
  logic [3:0]  data_be;
  logic [13:0] data_addr;
  logic [31:0] data_wdata, data_rdata;
  logic        ram_we;
  logic [13:0] ram_addr;
  logic [31:0] ram_din, ram_dout;

  // Second instance with fixed priority, RAM side left dangling.
  logic        f_instr_req, f_data_req, f_instr_gnt, f_data_gnt;
  logic        f_instr_rvalid, f_data_rvalid, f_ram_we;
  logic [31:0] f_instr_rdata, f_data_rdata, f_ram_din;
  logic [13:0] f_ram_addr;
  logic [13:0] f_zero_addr = '0;
  logic [31:0] f_zero_word = '0;
  logic [3:0]  f_zero_be   = '0;
  logic        f_zero_bit  = 1'b0;

  logic [31:0] ram_mem   [0:4095];
  logic [31:0] model_mem [0:4095];

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int cyc    = 0;

  typedef struct {
    int          due;
    bit          port_data;
    bit          is_load;
    logic [31:0] data;
  } resp_t;
  resp_t resp_q[$];

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_W(14), .ARB_RR(1)) u_dut (
    .clk(clk), .rstn(rstn),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt),
    .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata),
    .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be),
    .data_addr_i(data_addr), .data_wdata_i(data_wdata), .data_gnt_o(data_gnt),
    .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata),
    .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_din_o(ram_din), .ram_dout_i(ram_dout)
  );

  ram_port_arbiter #(.ADDR_W(14), .ARB_RR(0)) u_dut_fixed (
    .clk(clk), .rstn(rstn),
    .instr_req_i(f_instr_req), .instr_addr_i(f_zero_addr), .instr_gnt_o(f_instr_gnt),
    .instr_rvalid_o(f_instr_rvalid), .instr_rdata_o(f_instr_rdata),
    .data_req_i(f_data_req), .data_we_i(f_zero_bit), .data_be_i(f_zero_be),
    .data_addr_i(f_zero_addr), .data_wdata_i(f_zero_word), .data_gnt_o(f_data_gnt),
    .data_rvalid_o(f_data_rvalid), .data_rdata_o(f_data_rdata),
    .ram_we_o(f_ram_we), .ram_addr_o(f_ram_addr), .ram_din_o(f_ram_din), .ram_dout_i(f_zero_word)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEADBEEF;
    if (i == 8) return 32'hAABBCCDD;
    return (32'h9E3779B9 * i) ^ 32'h12345678;
  endfunction

  // Word-wide synchronous RAM, read-first, 1-cycle read latency.
  initial begin
    for (int i = 0; i < 4096; i++) ram_mem[i] <= init_word(i);
    ram_dout <= '0;
    forever begin
      @(posedge clk);
      ram_dout <= ram_mem[ram_addr[13:2]];
      if (ram_we) ram_mem[ram_addr[13:2]] <= ram_din;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  bit          i_pend, d_pend, stall, last_data;
  bit          exp_iv, exp_dv, exp_ig, exp_dg;
  logic [31:0] exp_rd;
  resp_t       r;
  int          w;

  initial begin
    for (int i = 0; i < 4096; i++) model_mem[i] = init_word(i);
    rstn = 1'b0;
    instr_req = 1'b1; instr_addr = 14'h0010;
    data_req = 1'b0; data_we = 1'b0; data_be = 4'h0; data_addr = '0; data_wdata = '0;
    f_instr_req = 1'b0; f_data_req = 1'b0;

    // Reset held with a pending fetch: nothing may be granted or written.
    tick(); tick();
    check("rst_instr_gnt", instr_gnt, 1'b0);
    check("rst_instr_rvalid", instr_rvalid, 1'b0);
    check("rst_data_rvalid", data_rvalid, 1'b0);
    check("rst_ram_we", ram_we, 1'b0);
    rstn = 1'b1;
    #1;
    check("fetch_gnt", instr_gnt, 1'b1);
    check("fetch_ram_addr", ram_addr, 14'h0010);
    tick();
    instr_req = 1'b0;
    check("fetch_rvalid", instr_rvalid, 1'b1);
    check("fetch_rdata", instr_rdata, 32'hDEADBEEF);
    tick();
    check("fetch_rvalid_drop", instr_rvalid, 1'b0);

    // Partial store: one stall cycle, merged write, rvalid two cycles after grant.
    data_req = 1'b1; data_we = 1'b1; data_be = 4'b0101; data_addr = 14'h0020; data_wdata = 32'h11223344;
    #1;
    check("rmw_gnt", data_gnt, 1'b1);
    check("rmw_read_we", ram_we, 1'b0);
    tick();
    data_req = 1'b0;
    instr_req = 1'b1; instr_addr = 14'h0010;
    #1;
    check("rmw_stall_igrant", instr_gnt, 1'b0);
    check("rmw_stall_dgrant", data_gnt, 1'b0);
    check("rmw_write_we", ram_we, 1'b1);
    check("rmw_write_din", ram_din, 32'hAA22CC44);
    check("rmw_no_early_rvalid", data_rvalid, 1'b0);
    tick();
    check("rmw_rvalid", data_rvalid, 1'b1);
    check("rmw_next_grant", instr_gnt, 1'b1);
    check("rmw_ram_word", ram_mem[8], 32'hAA22CC44);
    tick();
    instr_req = 1'b0;
    check("post_rmw_fetch", instr_rdata, 32'hDEADBEEF);

    // Full store followed immediately by a load of the same word.
    data_req = 1'b1; data_we = 1'b1; data_be = 4'hF; data_addr = 14'h0030; data_wdata = 32'hCAFEF00D;
    #1;
    check("st_gnt", data_gnt, 1'b1);
    check("st_we", ram_we, 1'b1);
    tick();
    data_we = 1'b0;
    #1;
    check("st_rvalid", data_rvalid, 1'b1);
    check("ld_gnt", data_gnt, 1'b1);
    tick();
    data_req = 1'b0;
    check("ld_rvalid", data_rvalid, 1'b1);
    check("ld_rdata", data_rdata, 32'hCAFEF00D);
    tick();
    check("ld_rvalid_drop", data_rvalid, 1'b0);
    model_mem[12] = 32'hCAFEF00D;
    model_mem[8]  = 32'hAA22CC44;

    // Continuous contention: data won last, so fetch goes first and grants alternate.
    instr_req = 1'b1; instr_addr = 14'h0004;
    data_req = 1'b1; data_we = 1'b0; data_addr = 14'h0008;
    f_instr_req = 1'b1; f_data_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("rr_instr_gnt_%0d", k), instr_gnt, (k % 2) == 0);
      check($sformatf("rr_data_gnt_%0d", k), data_gnt, (k % 2) == 1);
      check($sformatf("fixed_data_gnt_%0d", k), f_data_gnt, 1'b1);
      check($sformatf("fixed_instr_gnt_%0d", k), f_instr_gnt, 1'b0);
      tick();
    end
    instr_req = 1'b0; data_req = 1'b0; f_instr_req = 1'b0; f_data_req = 1'b0;
    tick();

    // Reset while the merged write is pending: the write and its response are dropped.
    data_req = 1'b1; data_we = 1'b1; data_be = 4'b0011; data_addr = 14'h0040; data_wdata = 32'h55667788;
    #1;
    check("rst_rmw_gnt", data_gnt, 1'b1);
    tick();
    data_req = 1'b0;
    rstn = 1'b0;
    #1;
    check("rst_rmw_we", ram_we, 1'b0);
    tick();
    check("rst_rmw_rvalid", data_rvalid, 1'b0);
    check("rst_rmw_word", ram_mem[16], init_word(16));
    rstn = 1'b1;
    tick();
    check("rst_rmw_rvalid2", data_rvalid, 1'b0);
    instr_req = 1'b1; instr_addr = 14'h0010;
    #1;
    check("rst_rmw_idle_gnt", instr_gnt, 1'b1);
    tick();
    instr_req = 1'b0;
    check("rst_rmw_fetch", instr_rdata, 32'hDEADBEEF);

    // Random traffic against the transaction model.
    i_pend = 0; d_pend = 0; stall = 0; last_data = 0;
    for (int k = 0; k < 400; k++) begin
      tick();
      exp_iv = 0; exp_dv = 0; exp_rd = '0;
      if (resp_q.size() > 0 && resp_q[0].due == cyc) begin
        r = resp_q.pop_front();
        if (r.port_data) exp_dv = 1; else exp_iv = 1;
        if (r.is_load) begin
          exp_rd = r.data;
          check("rnd_rdata", r.port_data ? data_rdata : instr_rdata, exp_rd);
        end
      end
      check("rnd_instr_rvalid", instr_rvalid, exp_iv);
      check("rnd_data_rvalid", data_rvalid, exp_dv);
      if (!i_pend) begin
        instr_req = ($urandom_range(0, 2) != 0);
        if (instr_req) begin
          instr_addr = 14'h0100 + 14'($urandom_range(0, 63));
          i_pend = 1;
        end
      end
      if (!d_pend) begin
        data_req = ($urandom_range(0, 2) != 0);
        if (data_req) begin
          data_addr  = 14'h0100 + 14'($urandom_range(0, 63));
          data_we    = $urandom_range(0, 1);
          case ($urandom_range(0, 3))
            0:       data_be = 4'hF;
            1:       data_be = 4'h0;
            default: data_be = 4'($urandom_range(1, 14));
          endcase
          data_wdata = $urandom;
          d_pend = 1;
        end
      end
      #1;
      exp_ig = 0; exp_dg = 0;
      if (stall) stall = 0;
      else if (i_pend && d_pend) begin
        if (last_data) exp_ig = 1; else exp_dg = 1;
      end else if (i_pend) exp_ig = 1;
      else if (d_pend) exp_dg = 1;
      check("rnd_instr_gnt", instr_gnt, exp_ig);
      check("rnd_data_gnt", data_gnt, exp_dg);
      if (exp_ig) begin
        resp_q.push_back('{cyc + 1, 1'b0, 1'b1, model_mem[instr_addr[13:2]]});
        i_pend = 0; last_data = 0;
      end
      if (exp_dg) begin
        w = data_addr[13:2];
        if (!data_we) begin
          resp_q.push_back('{cyc + 1, 1'b1, 1'b1, model_mem[w]});
        end else begin
          for (int b = 0; b < 4; b++)
            if (data_be[b]) model_mem[w][8*b +: 8] = data_wdata[8*b +: 8];
          if (data_be == 4'hF || data_be == 4'h0) begin
            resp_q.push_back('{cyc + 1, 1'b1, 1'b0, 32'h0});
          end else begin
            resp_q.push_back('{cyc + 2, 1'b1, 1'b0, 32'h0});
            stall = 1;
          end
        end
        d_pend = 0; last_data = 1;
      end
    end
    instr_req = 1'b0; data_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_iv = 0; exp_dv = 0;
      if (resp_q.size() > 0 && resp_q[0].due == cyc) begin
        r = resp_q.pop_front();
        if (r.port_data) exp_dv = 1; else exp_iv = 1;
        if (r.is_load) check("drain_rdata", r.port_data ? data_rdata : instr_rdata, r.data);
      end
      check("drain_instr_rvalid", instr_rvalid, exp_iv);
      check("drain_data_rvalid", data_rvalid, exp_dv);
    end
    check("drain_queue_empty", resp_q.size(), 0);
    for (int i = 64; i < 80; i++) check($sformatf("mem_word_%0d", i), ram_mem[i], model_mem[i]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
